ps2_cmd_arbiter: RTL and testbench

PS2_CMD_ARBITER -- requirements
Module: ps2_cmd_arbiter

---
 rtl/ps2_cmd_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_cmd_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_arbiter.sv
// ps2_cmd_arbiter: arbitrates two PS/2 command requesters onto a single
// ps2_tx write port, collects the device ack byte from the ps2_rx stream and
// reports the result. Rx bytes that are not taken as an ack are forwarded.
// Build option: define PS2_ARB_RETRY_EN to resend on 0xFE (up to MAX_RETRY
// resends); without it, 0xFE immediately reports "resend exhausted".
module ps2_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       done0,
  output logic       done1,
  output logic [1:0] status,
  output logic       busy,
  output logic       wr_en,
  output logic [7:0] wr_data,
  input  logic       wr_done,
  input  logic       rd_vld,
  input  logic [7:0] rd_data,
  output logic       fwd_vld,
  output logic [7:0] fwd_data
);

  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_ERR    = 8'hFC;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;

  localparam logic [1:0] ST_ACK     = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RESEND  = 2'b11;

  // Timeout counter only has to reach TIMEOUT_CYC-1.
  localparam int unsigned TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  if (TIMEOUT_CYC < 2 || MAX_RETRY > 65535) begin : g_bad_param
    $error("ps2_cmd_arbiter: TIMEOUT_CYC must be >= 2 and MAX_RETRY <= 65535");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_DONE,
    S_WAIT_ACK,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic          arm_q;
  logic          grant_q, grant_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    status_q, status_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          fwd_vld_q;
  logic [7:0]    fwd_data_q;

  logic is_ack, is_err, is_resend, ack_byte, timeout_hit, fwd_take;
  logic retry_ok;

`ifdef PS2_ARB_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  logic [RW-1:0] retry_q, retry_d;

  // Resend count: bumps on each honoured 0xFE, cleared when the result is reported.
  always_comb begin
    retry_d = retry_q;
    if (state_q == S_RESP) begin
      retry_d = '0;
    end else if (state_q == S_WAIT_ACK && rd_vld && is_resend && retry_ok) begin
      retry_d = retry_q + 1'b1;
    end
  end

  // Resend count register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) retry_q <= '0;
    else        retry_q <= retry_d;
  end

  assign retry_ok = (retry_q < MAX_R);
`else
  assign retry_ok = 1'b0;
`endif

  assign is_ack      = (rd_data == BYTE_ACK);
  assign is_err      = (rd_data == BYTE_ERR);
  assign is_resend   = (rd_data == BYTE_RESEND);
  assign ack_byte    = rd_vld && (is_ack || is_err || is_resend);
  assign timeout_hit = (tmo_q == TO_LAST);

  // State, grant, latched command and result registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      arm_q    <= 1'b0;
      grant_q  <= 1'b0;
      data_q   <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      arm_q    <= 1'b1;
      grant_q  <= grant_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  // Next-state: fixed-priority grant, write handshake and ack decode.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    data_d   = data_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        // arm_q holds off the first grant until the second edge after reset release.
        if (arm_q && (req0 || req1)) begin
          grant_d = !req0;
          data_d  = req0 ? data0 : data1;
          state_d = S_SEND;
        end
      end
      S_SEND: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (wr_done) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // An rx byte on the timeout cycle takes precedence over the timeout.
        if (rd_vld) begin
          if (is_ack) begin
            status_d = ST_ACK;
            state_d  = S_RESP;
          end else if (is_err) begin
            status_d = ST_ERR;
            state_d  = S_RESP;
          end else if (is_resend) begin
            if (retry_ok) begin
              state_d = S_SEND;
            end else begin
              status_d = ST_RESEND;
              state_d  = S_RESP;
            end
          end
        end else if (timeout_hit) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Ack timeout counter: cleared on write completion, saturates at TIMEOUT_CYC-1.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_WAIT_DONE && wr_done) begin
      tmo_d = '0;
    end else if (state_q == S_WAIT_ACK && !timeout_hit) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end

  // Only ack-class bytes seen while waiting for the ack are consumed.
  assign fwd_take = rd_vld && !(state_q == S_WAIT_ACK && ack_byte);

  // Forwarded rx byte register, one cycle behind rd_vld.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fwd_vld_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_vld_q <= fwd_take;
      if (fwd_take) fwd_data_q <= rd_data;
    end
  end

  // Outputs decoded from the state register.
  always_comb begin
    wr_en    = (state_q == S_SEND);
    wr_data  = data_q;
    busy     = (state_q != S_IDLE);
    done0    = (state_q == S_RESP) && !grant_q;
    done1    = (state_q == S_RESP) && grant_q;
    status   = status_q;
    fwd_vld  = fwd_vld_q;
    fwd_data = fwd_data_q;
  end

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Directed bench for ps2_cmd_arbiter. Expected resend count follows
// PS2_ARB_RETRY_EN as compiled.
module tb_ps2_cmd_arbiter;

  localparam int unsigned TO = 20;
  localparam int unsigned MR = 3;
`ifdef PS2_ARB_RETRY_EN
  localparam int unsigned N_ROUNDS = MR + 1;
`else
  localparam int unsigned N_ROUNDS = 1;
`endif

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       done0, done1, busy, wr_en, fwd_vld;
  logic [1:0] status;
  logic [7:0] wr_data, fwd_data;
  logic       wr_done = 1'b0;
  logic       rd_vld  = 1'b0;
  logic [7:0] rd_data = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int done_cnt = 0;
  int snap_wr, snap_done;
  logic seen;

  ps2_cmd_arbiter #(.TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .data0   (data0),
    .data1   (data1),
    .done0   (done0),
    .done1   (done1),
    .status  (status),
    .busy    (busy),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .wr_done (wr_done),
    .rd_vld  (rd_vld),
    .rd_data (rd_data),
    .fwd_vld (fwd_vld),
    .fwd_data(fwd_data)
  );

  always #5 clk_sys = ~clk_sys;

  // Pulse counters for write strobes and completion pulses.
  always @(posedge clk_sys) begin
    if (wr_en) wr_cnt <= wr_cnt + 1;
    if (done0 || done1) done_cnt <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick; tick;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_status", status, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fwd_vld", fwd_vld, 0);
    chk("rst_fwd_data", fwd_data, 0);

    // Basic command 0xFF with a pending request at reset release
    rst_n = 1'b1; req0 = 1'b1; data0 = 8'hFF;
    tick;
    chk("no_grant_first_edge", busy, 0);
    chk("no_wr_first_edge", wr_en, 0);
    tick;
    chk("t1_wr_en", wr_en, 1);
    chk("t1_wr_data", wr_data, 8'hFF);
    chk("t1_busy", busy, 1);
    req0 = 1'b0;
    tick;
    chk("t1_wr_en_one_cycle", wr_en, 0);
    repeat (99) tick;
    chk("t1_busy_waiting", busy, 1);
    chk("t1_no_early_done", done0, 0);
    wr_done = 1'b1; tick; wr_done = 1'b0;
    rd_vld = 1'b1; rd_data = 8'hFA; tick; rd_vld = 1'b0;
    chk("t1_done0", done0, 1);
    chk("t1_done1_low", done1, 0);
    chk("t1_status", status, 2'b00);
    chk("t1_busy_at_done", busy, 1);
    chk("t1_ack_not_fwd", fwd_vld, 0);
    tick;
    chk("t1_done0_one_cycle", done0, 0);
    chk("t1_busy_cleared", busy, 0);

    // Idle: ack byte forwarded, wr_done ignored
    wr_done = 1'b1; rd_vld = 1'b1; rd_data = 8'hFA; tick;
    wr_done = 1'b0; rd_vld = 1'b0;
    chk("idle_fwd_vld", fwd_vld, 1);
    chk("idle_fwd_data", fwd_data, 8'hFA);
    chk("idle_wr_done_ignored", busy, 0);
    tick;
    chk("idle_fwd_one_cycle", fwd_vld, 0);

    // Simultaneous requests: req0 first, req1 right after done0
    req0 = 1'b1; data0 = 8'hF4; req1 = 1'b1; data1 = 8'hE8; tick;
    chk("t2_wr_en0", wr_en, 1);
    chk("t2_wr_data0", wr_data, 8'hF4);
    req0 = 1'b0;
    tick; wr_done = 1'b1; tick; wr_done = 1'b0;
    rd_vld = 1'b1; rd_data = 8'hFA; tick; rd_vld = 1'b0;
    chk("t2_done0", done0, 1);
    chk("t2_done1_low", done1, 0);
    tick;
    chk("t2_gap_wr_en", wr_en, 0);
    chk("t2_gap_busy", busy, 0);
    tick;
    chk("t2_wr_en1", wr_en, 1);
    chk("t2_wr_data1", wr_data, 8'hE8);
    req1 = 1'b0;
    tick; wr_done = 1'b1; tick; wr_done = 1'b0;
    rd_vld = 1'b1; rd_data = 8'hFC; tick; rd_vld = 1'b0;
    chk("t2_done1", done1, 1);
    chk("t2_done0_low", done0, 0);
    chk("t2_status_err", status, 2'b01);
    tick;

    // Resend handling
    snap_wr = wr_cnt;
    req1 = 1'b1; data1 = 8'hED; tick; req1 = 1'b0;
    for (int i = 0; i < int'(N_ROUNDS); i++) begin
      chk("t3_resend_wr_en", wr_en, 1);
      chk("t3_resend_wr_data", wr_data, 8'hED);
      tick; wr_done = 1'b1; tick; wr_done = 1'b0;
      rd_vld = 1'b1; rd_data = 8'hFE; tick; rd_vld = 1'b0;
      chk("t3_fe_not_fwd", fwd_vld, 0);
      if (i < int'(N_ROUNDS) - 1) chk("t3_no_done_yet", done1, 0);
    end
    chk("t3_done1", done1, 1);
    chk("t3_status_exhausted", status, 2'b11);
    tick;
    chk("t3_wr_pulses", wr_cnt - snap_wr, N_ROUNDS);

    // Timeout exactly TO cycles after WAIT_ACK entry
    req0 = 1'b1; data0 = 8'hF2; tick; req0 = 1'b0;
    tick; wr_done = 1'b1; tick; wr_done = 1'b0;
    seen = 1'b0;
    for (int k = 1; k < int'(TO); k++) begin
      tick;
      if (done0) seen = 1'b1;
    end
    chk("t4_no_early_timeout", seen, 0);
    tick;
    chk("t4_done0", done0, 1);
    chk("t4_status_timeout", status, 2'b10);
    tick;

    // Ack on the timeout cycle is honoured
    req0 = 1'b1; data0 = 8'hF3; tick; req0 = 1'b0;
    tick; wr_done = 1'b1; tick; wr_done = 1'b0;
    repeat (TO - 1) tick;
    rd_vld = 1'b1; rd_data = 8'hFA; tick; rd_vld = 1'b0;
    chk("t4b_done0", done0, 1);
    chk("t4b_status_ack", status, 2'b00);
    chk("t4b_ack_not_fwd", fwd_vld, 0);
    tick;

    // Non-ack byte during WAIT_ACK is forwarded
    req1 = 1'b1; data1 = 8'hF6; tick; req1 = 1'b0;
    tick; wr_done = 1'b1; tick; wr_done = 1'b0;
    rd_vld = 1'b1; rd_data = 8'h08; tick; rd_vld = 1'b0;
    chk("t5_fwd_vld", fwd_vld, 1);
    chk("t5_fwd_data", fwd_data, 8'h08);
    chk("t5_still_waiting", done1, 0);
    chk("t5_busy", busy, 1);
    rd_vld = 1'b1; rd_data = 8'hFA; tick; rd_vld = 1'b0;
    chk("t5_fa_not_fwd", fwd_vld, 0);
    chk("t5_done1", done1, 1);
    chk("t5_status", status, 2'b00);
    tick;

    // Reset in WAIT_DONE with req1 held
    snap_done = done_cnt;
    req1 = 1'b1; data1 = 8'hF5; tick; tick;
    chk("t6_busy_pre", busy, 1);
    chk("t6_wr_en_pre", wr_en, 0);
    rst_n = 1'b0; #1;
    chk("t6_rst_wr_en", wr_en, 0);
    chk("t6_rst_wr_data", wr_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done0", done0, 0);
    chk("t6_rst_done1", done1, 0);
    chk("t6_rst_status", status, 0);
    chk("t6_rst_fwd_vld", fwd_vld, 0);
    chk("t6_rst_fwd_data", fwd_data, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk("t6_no_grant_first_edge", busy, 0);
    tick;
    chk("t6_regrant_wr_en", wr_en, 1);
    chk("t6_regrant_wr_data", wr_data, 8'hF5);
    chk("t6_no_done_pulse", done_cnt - snap_done, 0);
    req1 = 1'b0;
    tick; wr_done = 1'b1; tick; wr_done = 1'b0;
    rd_vld = 1'b1; rd_data = 8'hFA; tick; rd_vld = 1'b0;
    chk("t6_done1", done1, 1);
    chk("t6_status", status, 2'b00);
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
